branch_predictor_gshare: RTL

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

---
 rtl/branch_predictor_gshare.sv | 125 ++++++++++++
 1 files changed

// File: rtl/branch_predictor_gshare.sv
// Branch direction predictor: a register-based table of saturating counters indexed
// by PC (bimodal) or PC XOR global history (gshare), with a 1-cycle registered lookup.
module branch_predictor_gshare #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = 6,
  parameter int unsigned MODE       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_pc,
  output logic                  prediction,
  output logic                  pred_out_valid,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  output logic [15:0]           mispred_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t CTR_MAX  = '1;
  // Weakly not-taken: 2^(CTR_BITS-1)-1, which is 0 for a 1-bit counter.
  localparam ctr_t CTR_INIT = CTR_MAX >> 1;

  localparam logic [15:0] MISPRED_MAX = 16'hFFFF;

  ctr_t                  table_q [ENTRIES];
  ctr_t                  table_d [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic                  prediction_q, prediction_d;
  logic                  pred_out_valid_q, pred_out_valid_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
  logic [15:0]           mispred_count_q, mispred_count_d;

  logic [INDEX_BITS-1:0] hist_ext;
  logic [INDEX_BITS-1:0] lookup_idx;
  ctr_t                  upd_ctr;
  ctr_t                  upd_ctr_next;
  logic                  upd_mispred;

  // Only the word-aligned index field of the PC takes part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    hist_ext                  = '0;
    hist_ext[HIST_BITS-1:0]   = ghr_q;
    lookup_idx                = pred_pc[INDEX_BITS+1:2];
    if (MODE != 0) begin
      lookup_idx = lookup_idx ^ hist_ext;
    end
  end

  always_comb begin
    upd_ctr      = table_q[upd_index];
    upd_ctr_next = upd_ctr;
    if (upd_taken && (upd_ctr != CTR_MAX)) begin
      upd_ctr_next = upd_ctr + ctr_t'(1);
    end else if (!upd_taken && (upd_ctr != '0)) begin
      upd_ctr_next = upd_ctr - ctr_t'(1);
    end
    upd_mispred = (upd_taken != upd_ctr[CTR_BITS-1]);
  end

  // Lookup reads table_q/ghr_q, so a same-cycle update is never visible to it.
  always_comb begin
    table_d          = table_q;
    ghr_d            = ghr_q;
    prediction_d     = prediction_q;
    pred_index_d     = pred_index_q;
    pred_out_valid_d = pred_valid;
    mispred_count_d  = mispred_count_q;

    if (pred_valid) begin
      prediction_d = table_q[lookup_idx][CTR_BITS-1];
      pred_index_d = lookup_idx;
    end

    if (upd_valid) begin
      table_d[upd_index] = upd_ctr_next;
      ghr_d              = ghr_q << 1;
      ghr_d[0]           = upd_taken;
      if (upd_mispred && (mispred_count_q != MISPRED_MAX)) begin
        mispred_count_d = mispred_count_q + 16'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is flops rather than RAM precisely so that every entry
      // can be cleared in a single reset edge.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_INIT;
      end
      ghr_q            <= '0;
      prediction_q     <= 1'b0;
      pred_out_valid_q <= 1'b0;
      pred_index_q     <= '0;
      mispred_count_q  <= '0;
    end else begin
      table_q          <= table_d;
      ghr_q            <= ghr_d;
      prediction_q     <= prediction_d;
      pred_out_valid_q <= pred_out_valid_d;
      pred_index_q     <= pred_index_d;
      mispred_count_q  <= mispred_count_d;
    end
  end

  assign prediction     = prediction_q;
  assign pred_out_valid = pred_out_valid_q;
  assign pred_index     = pred_index_q;
  assign mispred_count  = mispred_count_q;

endmodule
